// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register (main + skid) with a registered in_ready.
// Optional saturating stall/transfer statistics are enabled by defining PIPE_STATS_EN.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned CTRL_W = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STATS_EN
   ,output logic [CNT_W-1:0]  stat_stall_cnt,
    output logic [CNT_W-1:0]  stat_xfer_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [RD_W-1:0]     main_rd_q, main_rd_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [RD_W-1:0]     skid_rd_q, skid_rd_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;

    logic up_fire;
    logic dn_fire;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign up_fire   = in_valid && in_ready_q;
    assign dn_fire   = out_valid && out_ready;

    assign out_data  = main_data_q;
    assign out_rd    = main_rd_q;
    assign out_ctrl  = main_ctrl_q;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        main_data_d = main_data_q;
        main_rd_d   = main_rd_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_rd_d   = skid_rd_q;
        skid_ctrl_d = skid_ctrl_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (up_fire) begin
                    state_d     = ST_MAIN;
                    main_data_d = in_data;
                    main_rd_d   = in_rd;
                    main_ctrl_d = in_ctrl;
                end
            end
            ST_MAIN: begin
                if (up_fire && dn_fire) begin
                    main_data_d = in_data;
                    main_rd_d   = in_rd;
                    main_ctrl_d = in_ctrl;
                end else if (dn_fire) begin
                    state_d = ST_EMPTY;
                end else if (up_fire) begin
                    state_d     = ST_FULL;
                    skid_data_d = in_data;
                    skid_rd_d   = in_rd;
                    skid_ctrl_d = in_ctrl;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the downstream side can move.
                if (dn_fire) begin
                    state_d     = ST_MAIN;
                    main_data_d = skid_data_q;
                    main_rd_d   = skid_rd_q;
                    main_ctrl_d = skid_ctrl_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Flush drops everything, including an entry arriving this cycle.
        if (flush) begin
            state_d = ST_EMPTY;
        end

        in_ready_d = (state_d != ST_FULL);
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            // NOTE: payload is cleared on reset because out_data/out_rd/out_ctrl must read 0 afterwards.
            main_data_q <= '0;
            main_rd_q   <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_rd_q   <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_data_q <= main_data_d;
            main_rd_q   <= main_rd_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_rd_q   <= skid_rd_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

`ifdef PIPE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    // Counters saturate; flush leaves them alone.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        xfer_cnt_d  = xfer_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (dn_fire && (xfer_cnt_q != CNT_MAX)) begin
            xfer_cnt_d = xfer_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign stat_stall_cnt = stall_cnt_q;
    assign stat_xfer_cnt  = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the model is a FIFO of accepted entries with capacity 2.
// Statistics checks are included when PIPE_STATS_EN is defined.
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned CTRL_W = 2;
    localparam int unsigned CNT_W  = 4;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [RD_W-1:0]   rd;
        logic [CTRL_W-1:0] c;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [RD_W-1:0]   in_rd = '0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [RD_W-1:0]   out_rd;
    logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0]  stat_stall_cnt;
    logic [CNT_W-1:0]  stat_xfer_cnt;
`endif

    pipe_stage_reg #(
        .DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_rd(in_rd), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd), .out_ctrl(out_ctrl)
`ifdef PIPE_STATS_EN
       ,.stat_stall_cnt(stat_stall_cnt), .stat_xfer_cnt(stat_xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    ent_t exp_q[$];
    bit   chk_en = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: occupancy-derived handshake outputs, and in-order payload on each downstream fire.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
            if (out_valid && out_ready && exp_q.size() != 0) begin
                ent_t e;
                e = exp_q.pop_front();
                check("out_data", out_data, e.d);
                check("out_rd", 64'(out_rd), 64'(e.rd));
                check("out_ctrl", 64'(out_ctrl), 64'(e.c));
            end
        end
    end

    // One clock of stimulus; the model is updated after the monitor has sampled this cycle.
    task automatic cycle(input logic v, input ent_t e, input logic ordy, input logic fl, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = e.d;
        in_rd     = e.rd;
        in_ctrl   = e.c;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(negedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            chk_en = 1'b1;
        end else if (fl) begin
            exp_q.delete();
        end else if (v && in_ready) begin
            exp_q.push_back(e);
        end
    endtask

    function automatic ent_t mk(input logic [63:0] d, input int rd, input int c);
        ent_t e;
        e.d  = d;
        e.rd = RD_W'(rd);
        e.c  = CTRL_W'(c);
        return e;
    endfunction

    ent_t z, ea, eb, ec, ed;

    initial begin
        z  = mk(64'h0, 0, 0);
        ea = mk(64'h1111, 3, 3);
        eb = mk(64'hB0B0_0000_0000_000B, 7, 1);
        ec = mk(64'hC0C0_0000_0000_000C, 9, 2);
        ed = mk(64'hDEAD_0000_0000_000D, 13, 3);

        // Reset state.
        cycle(0, z, 0, 0, 1);
        cycle(0, z, 0, 0, 0);
        check("rst out_data", out_data, 64'h0);
        check("rst out_rd", 64'(out_rd), 64'h0);
        check("rst out_ctrl", 64'(out_ctrl), 64'h0);

        // Single entry A, then empty.
        cycle(1, ea, 1, 0, 0);
        cycle(0, z, 1, 0, 0);
        check("A visible", out_data, 64'h1111);
        cycle(0, z, 1, 0, 0);

        // Streaming 0..7 with out_ready held high.
        for (int i = 0; i < 8; i++) cycle(1, mk(64'(i), i, i), 1, 0, 0);
        cycle(0, z, 1, 0, 0);
        cycle(0, z, 1, 0, 0);

        // Back-pressure into FULL, hold, then drain B then C.
        cycle(1, eb, 0, 0, 0);
        cycle(1, ec, 0, 0, 0);
        cycle(0, z, 0, 0, 0);
        check("full in_ready", 64'(in_ready), 64'h0);
        check("full holds B", out_data, eb.d);
        cycle(0, z, 0, 0, 0);
        check("full still B", out_data, eb.d);
        cycle(0, z, 1, 0, 0);
        cycle(0, z, 1, 0, 0);
        cycle(0, z, 1, 0, 0);

        // Flush in FULL with D offered; D must never appear.
        cycle(1, eb, 0, 0, 0);
        cycle(1, ec, 0, 0, 0);
        cycle(1, ed, 0, 1, 0);
        cycle(0, z, 1, 0, 0);
        check("flush out_valid", 64'(out_valid), 64'h0);
        check("flush in_ready", 64'(in_ready), 64'h1);
        // Flush in MAIN with a same-cycle upstream fire.
        cycle(1, ea, 0, 0, 0);
        cycle(1, ed, 0, 1, 0);
        cycle(0, z, 1, 0, 0);
        cycle(0, z, 1, 0, 0);

        // Reset in MAIN together with flush and an upstream fire.
        cycle(1, eb, 0, 0, 0);
        cycle(1, ec, 0, 1, 1);
        cycle(0, z, 0, 0, 0);
        check("rst2 out_valid", 64'(out_valid), 64'h0);
        check("rst2 out_data", out_data, 64'h0);
        check("rst2 in_ready", 64'(in_ready), 64'h1);

`ifdef PIPE_STATS_EN
        // 20 stalled cycles saturate a 4-bit counter; 3 transfers follow.
        cycle(0, z, 0, 0, 1);
        cycle(1, ea, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, z, 0, 0, 0);
        cycle(1, eb, 1, 0, 0);
        cycle(1, ec, 1, 0, 0);
        cycle(0, z, 1, 0, 0);
        cycle(0, z, 0, 1, 0);
        cycle(0, z, 0, 0, 0);
        check("stat_stall_cnt", 64'(stat_stall_cnt), 64'd15);
        check("stat_xfer_cnt", 64'(stat_xfer_cnt), 64'd3);
`endif

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            ent_t e;
            e.d  = {$urandom(), $urandom()};
            e.rd = RD_W'($urandom());
            e.c  = CTRL_W'($urandom());
            cycle(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0, e,
                  ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 199) < 1) ? 1'b1 : 1'b0);
        end

        // Drain whatever is left.
        for (int i = 0; i < 4; i++) cycle(0, z, 1, 0, 0);
        check("drained", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 64, payload width (two 32-bit result words).
REQ-002 Parameter RD_W, default 5, destination-register index width.
REQ-003 Parameter CTRL_W, default 2, control-bit width (bit1 mem2reg, bit0 regwr).
REQ-004 Parameter CNT_W, default 16, statistics counter width.
REQ-005 Port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, synchronous, active-high reset.
REQ-007 Port flush, input, 1, discard all held entries.
REQ-008 Port in_valid, input, 1, upstream entry present.
REQ-009 Port in_ready, output, 1, stage accepts an entry this cycle.
REQ-010 Ports in_data, in_rd and in_ctrl, inputs, DATA_W, RD_W and CTRL_W, upstream payload.
REQ-011 Port out_valid, output, 1, downstream entry present.
REQ-012 Port out_ready, input, 1, downstream consumes this cycle.
REQ-013 Ports out_data, out_rd and out_ctrl, outputs, DATA_W, RD_W and CTRL_W, downstream payload.
REQ-014 Ports stat_stall_cnt and stat_xfer_cnt, outputs, CNT_W each, present only with PIPE_STATS_EN.

Function
REQ-015 The stage SHALL hold a main entry and a one-entry skid entry, giving three states: EMPTY, MAIN and FULL.
REQ-016 Upstream handshake SHALL fire when in_valid && in_ready; downstream handshake SHALL fire when out_valid && out_ready.
REQ-017 in_ready SHALL be a direct register output, equal to 1 in EMPTY and MAIN and 0 in FULL, with no combinational path from out_ready.
REQ-018 out_valid SHALL be 1 in MAIN and FULL; out_data, out_rd and out_ctrl SHALL always show the main entry.
REQ-019 EMPTY -> MAIN on an upstream fire; the entry SHALL appear on the outputs exactly 1 cycle after acceptance.
REQ-020 MAIN -> MAIN on simultaneous upstream and downstream fires; the main entry SHALL be replaced by the input.
REQ-021 MAIN -> EMPTY on a downstream fire with no upstream fire.
REQ-022 MAIN -> FULL on an upstream fire without a downstream fire; the input SHALL be stored in skid.
REQ-023 FULL -> MAIN on a downstream fire; skid SHALL move to main and in_ready SHALL rise the next cycle.
REQ-024 FULL with out_ready=0 SHALL hold all contents unchanged.
REQ-025 Entries SHALL leave in acceptance order, with none lost or duplicated.
REQ-026 Flush=1 SHALL force EMPTY next cycle, and any same-cycle upstream fire SHALL be discarded.
REQ-027 Flush SHALL have priority over every handshake, and in_ready SHALL be 1 the cycle after a flush.
REQ-028 Payload registers SHALL update only on the transitions above, and their value while out_valid=0 is don't-care.

Reset
REQ-029 rst=1 at a clock edge SHALL force EMPTY, so out_valid=0, in_ready=1, out_data=0, out_rd=0 and out_ctrl=0 the following cycle.
REQ-030 rst SHALL have priority over flush and handshakes, and reset mid-transfer SHALL discard held entries.
REQ-031 With PIPE_STATS_EN, rst SHALL clear both counters to 0, while flush SHALL not clear them.

Configuration
REQ-032 Macro PIPE_STATS_EN defined: stat_stall_cnt SHALL increment each cycle with out_valid=1 and out_ready=0.
REQ-033 Macro PIPE_STATS_EN defined: stat_xfer_cnt SHALL increment each downstream fire.
REQ-034 Macro PIPE_STATS_EN defined: both counters SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-035 Macro PIPE_STATS_EN undefined: both ports and all counter logic SHALL be absent, and handshake behaviour SHALL be identical.

Verification
REQ-036 Accept A=0x1111 with rd=3 and ctrl=2'b11, out_ready=1: out_valid=1 next cycle with A, rd=3 and ctrl=3, then EMPTY the following cycle.
REQ-037 Streaming: 8 back-to-back entries 0..7 with out_ready=1 SHALL give 8 consecutive outputs 0..7, in_ready constantly 1.
REQ-038 Back-pressure: out_ready=0 while sending B and C SHALL reach FULL with in_ready=0 and out=B held; out_ready=1 SHALL then give B, C in order.
REQ-039 Flush in FULL with in_valid=1 and D present SHALL give out_valid=0 and in_ready=1 next cycle, and D SHALL never appear.
REQ-040 rst asserted in MAIN at the same edge as a flush and an upstream fire SHALL give out_valid=0, out_data=0 and in_ready=1 next cycle.
REQ-041 With PIPE_STATS_EN and CNT_W=4, 20 stalled cycles then 3 transfers SHALL give stat_stall_cnt=15 and stat_xfer_cnt=3.
